// File: rtl/crack_pkg.sv
// Shared types and constants for the crack_report display/timing block.
package crack_pkg;

    localparam int unsigned KEY_W = 24;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LO,
        WAIT_HI,
        SHOW
    } state_t;

endpackage

// File: rtl/crack_report_hex7seg.sv
// Hex digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/crack_report.sv
// Launches one cracker search, times it, captures the key and drives six HEX digits.
// Optional macro CRACK_REPORT_BLINK_EN: blink the not-found dashes every BLINK_DIV cycles.
module crack_report
    import crack_pkg::*;
#(
    parameter int unsigned      CNT_W     = 32,
    parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(32'hFFFF_FFFF),
    parameter int unsigned      BLINK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             crk_rdy,
    output logic             crk_en,
    input  logic [KEY_W-1:0] crk_key,
    input  logic             crk_key_valid,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] key_q,
    output logic [CNT_W-1:0] cycles,
    output logic             timeout,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    state_t           state;
    logic [CNT_W-1:0] cycles_inc;
    logic [6:0]       seg  [6];
    logic [6:0]       disp [6];
    logic             blink_off;

    // The launch pulse must coincide with the first rdy=1 cycle in LAUNCH, so it cannot be registered.
    assign crk_en     = (state == LAUNCH) && crk_rdy;
    assign cycles_inc = (cycles == '1) ? cycles : cycles + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            timeout <= 1'b0;
            key_q   <= '0;
            cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LAUNCH;
                end
                LAUNCH: begin
                    if (crk_rdy) begin
                        cycles  <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    cycles  <= cycles_inc;
                    timeout <= timeout | (cycles_inc == TIMEOUT);
                    if (!crk_rdy) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    // The capture edge does not count, so cycles equals the cracker's latency.
                    if (crk_rdy) begin
                        key_q <= crk_key_valid ? crk_key : '0;
                        found <= crk_key_valid;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= SHOW;
                    end else begin
                        cycles  <= cycles_inc;
                        timeout <= timeout | (cycles_inc == TIMEOUT);
                    end
                end
                SHOW: begin
                    if (start) begin
                        done  <= 1'b0;
                        state <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRACK_REPORT_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != SHOW) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_blink_div;

    assign blink_off        = 1'b0;
    assign unused_blink_div = (BLINK_DIV != 0);
`endif

    for (genvar i = 0; i < 6; i++) begin : g_dig
        hex7seg u_hex7seg (
            .digit (key_q[4*i +: 4]),
            .seg   (seg[i])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            disp[i] = SEG_BLANK;
            if (state == SHOW) begin
                if (found) begin
                    disp[i] = seg[i];
                end else if (!blink_off) begin
                    disp[i] = SEG_DASH;
                end
            end
        end
    end

    assign hex0 = disp[0];
    assign hex1 = disp[1];
    assign hex2 = disp[2];
    assign hex3 = disp[3];
    assign hex4 = disp[4];
    assign hex5 = disp[5];

endmodule

// File: tb/tb_crack_report.sv
// Self-checking bench for crack_report with a timed cracker model driven from the tests.
module tb_crack_report;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned TO    = 100;
    localparam int unsigned BDIV  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             crk_rdy;
    logic             crk_en;
    logic [23:0]      crk_key;
    logic             crk_key_valid;
    logic             busy;
    logic             done;
    logic             found;
    logic [23:0]      key_q;
    logic [CNT_W-1:0] cycles;
    logic             timeout;
    logic [6:0]       hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0]      hex_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    crack_report #(
        .CNT_W     (CNT_W),
        .TIMEOUT   (CNT_W'(TO)),
        .BLINK_DIV (BDIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .crk_rdy       (crk_rdy),
        .crk_en        (crk_en),
        .crk_key       (crk_key),
        .crk_key_valid (crk_key_valid),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .key_q         (key_q),
        .cycles        (cycles),
        .timeout       (timeout),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // mode 0 = blank, 1 = key digits, 2 = dashes
    function automatic logic [41:0] disp_of(input int mode, input logic [23:0] key);
        logic [41:0] r;
        for (int i = 0; i < 6; i++)
            r[7*i +: 7] = (mode == 0) ? 7'h7F : (mode == 2) ? 7'h3F : seg_of(key[4*i +: 4]);
        return r;
    endfunction

    // One full search: start pulse (optionally held), cracker busy for `hold` cycles,
    // then a search of latency n; optional extra start pulse at absolute step extra_start.
    task automatic do_search(input int n, input bit valid, input logic [23:0] key,
                             input int hold, input int start_len, input int extra_start);
        int step;
        step = 0;
        @(negedge clk);
        start = 1'b1;
        crk_rdy = (hold == 0);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            step++;
            start = (step < start_len) || (step == extra_start);
            if (h == hold) crk_rdy = 1'b1;
            #1;
            checks++;
            if (crk_en !== (h == hold)) begin
                errors++;
                $display("FAIL launch_en h=%0d: got %b want %b", h, crk_en, (h == hold));
            end
            checks++;
            if ({busy, done, hex_all} !== {1'b0, 1'b0, disp_of(0, 24'h0)}) begin
                errors++;
                $display("FAIL launch_state: got busy=%b done=%b hex=%h want 0 0 blank", busy, done, hex_all);
            end
        end
        @(negedge clk);
        step++;
        start = (step < start_len) || (step == extra_start);
        crk_rdy = 1'b0;
        crk_key = 24'($urandom);
        crk_key_valid = 1'($urandom);
        #1;
        checks++;
        if ({crk_en, busy, done, timeout} !== 4'b0100 || cycles !== '0) begin
            errors++;
            $display("FAIL launched: got en=%b busy=%b done=%b to=%b cyc=%0d want 0 1 0 0 0",
                     crk_en, busy, done, timeout, cycles);
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            step++;
            start = (step < start_len) || (step == extra_start);
            if (k == n) begin
                crk_rdy = 1'b1;
                crk_key = key;
                crk_key_valid = valid;
            end
            #1;
            checks++;
            if (cycles !== CNT_W'(k)) begin
                errors++;
                $display("FAIL search_cycles k=%0d: got %0d want %0d", k, cycles, k);
            end
            checks++;
            if (timeout !== (k >= TO)) begin
                errors++;
                $display("FAIL search_timeout k=%0d: got %b want %b", k, timeout, (k >= TO));
            end
            checks++;
            if ({crk_en, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL search_flags k=%0d: got en,busy,done=%b want 010", k, {crk_en, busy, done});
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({crk_en, busy, done, found} !== {3'b001, valid}) begin
            errors++;
            $display("FAIL result_flags: got en,busy,done,found=%b want %b", {crk_en, busy, done, found}, {3'b001, valid});
        end
        checks++;
        if (key_q !== (valid ? key : 24'h0) || cycles !== CNT_W'(n) || timeout !== (n >= TO)) begin
            errors++;
            $display("FAIL result_data: got key=%h cyc=%0d to=%b want key=%h cyc=%0d to=%b",
                     key_q, cycles, timeout, (valid ? key : 24'h0), n, (n >= TO));
        end
        checks++;
        if (hex_all !== disp_of(valid ? 1 : 2, key)) begin
            errors++;
            $display("FAIL result_hex: got %h want %h", hex_all, disp_of(valid ? 1 : 2, key));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        crk_rdy = 1'b1;
        crk_key = 24'hABCDEF;
        crk_key_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({crk_en, busy, done, found, timeout} !== 5'b0 || key_q !== '0 || cycles !== '0) begin
            errors++;
            $display("FAIL reset_regs: got en=%b busy=%b done=%b found=%b to=%b key=%h cyc=%0d want all zero",
                     crk_en, busy, done, found, timeout, key_q, cycles);
        end
        checks++;
        if (hex_all !== disp_of(0, 24'h0)) begin
            errors++;
            $display("FAIL reset_hex: got %h want %h", hex_all, disp_of(0, 24'h0));
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if ({crk_en, busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_priority: got en,busy=%b want 00", {crk_en, busy});
            end
        end
    endtask

    task automatic test_find;
        do_search(1000, 1'b1, 24'h1E4600, 0, 1, -1);
        checks++;
        if (hex_all !== {7'h79, 7'h06, 7'h19, 7'h02, 7'h40, 7'h40}) begin
            errors++;
            $display("FAIL find_hex_const: got %h want 79,06,19,02,40,40", hex_all);
        end
    endtask

    task automatic test_not_found;
        logic [41:0] want;
        do_search(50, 1'b0, 24'h5A5A5A, 0, 1, -1);
        for (int j = 1; j < 12; j++) begin
            @(negedge clk);
            #1;
`ifdef CRACK_REPORT_BLINK_EN
            want = (((j / BDIV) % 2) == 0) ? disp_of(2, 24'h0) : disp_of(0, 24'h0);
`else
            want = disp_of(2, 24'h0);
`endif
            checks++;
            if (hex_all !== want || done !== 1'b1) begin
                errors++;
                $display("FAIL not_found_hex j=%0d: got %h done=%b want %h done=1", j, hex_all, done, want);
            end
        end
    endtask

    task automatic test_cracker_busy;
        do_search(30, 1'b1, 24'h00BEEF, 20, 1, -1);
    endtask

    task automatic test_timeout;
        do_search(150, 1'b1, 24'hC0FFEE, 0, 1, -1);
    endtask

    task automatic test_relaunch;
        do_search(60, 1'b1, 24'($urandom), 0, 1, 22);
    endtask

    task automatic test_start_held;
        do_search(40, 1'b0, 24'h0, 3, 12, -1);
    endtask

    task automatic test_random;
        for (int r = 0; r < 5; r++)
            do_search($urandom_range(1, 300), 1'($urandom), 24'($urandom), $urandom_range(0, 5), 1, -1);
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        start = 1'b1;
        crk_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        crk_rdy = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || cycles !== CNT_W'(30)) begin
            errors++;
            $display("FAIL mid_pre: got busy=%b cyc=%0d want 1 30", busy, cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        crk_rdy = 1'b1;
        #1;
        checks++;
        if ({crk_en, busy, done, found, timeout} !== 5'b0 || key_q !== '0 || cycles !== '0 ||
            hex_all !== disp_of(0, 24'h0)) begin
            errors++;
            $display("FAIL mid_reset: got en=%b busy=%b done=%b found=%b to=%b key=%h cyc=%0d hex=%h want reset values",
                     crk_en, busy, done, found, timeout, key_q, cycles, hex_all);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if ({crk_en, busy} !== 2'b00) begin
                errors++;
                $display("FAIL mid_idle: got en,busy=%b want 00", {crk_en, busy});
            end
        end
        do_search(10, 1'b1, 24'h123456, 0, 1, -1);
    endtask

    task automatic test_no_drop;
        @(negedge clk);
        start = 1'b1;
        crk_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (crk_en !== 1'b1) begin
            errors++;
            $display("FAIL nodrop_en: got %b want 1", crk_en);
        end
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (cycles !== CNT_W'(k) || timeout !== (k >= TO) || {crk_en, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL nodrop k=%0d: got cyc=%0d to=%b en,busy,done=%b want %0d %b 010",
                         k, cycles, timeout, {crk_en, busy, done}, k, (k >= TO));
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL nodrop_reset: got busy,to=%b want 00", {busy, timeout});
        end
    endtask

    initial begin
        test_reset;
        test_find;
        test_not_found;
        test_cracker_busy;
        test_timeout;
        test_relaunch;
        test_start_held;
        test_random;
        test_mid_reset;
        test_no_drop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crack_report.md
Name: crack_report

Overview:
- Downstream consumer of the double-cracker.
- Launches one key search on a user start pulse using the cracker's rdy/en handshake.
- Times the search, captures the 24-bit key and its found/not-found result, and drives six active-low seven-segment digits.
- Sits between board I/O (button, HEX0-HEX5) and the cracker top-level.

Parameters:
- CNT_W, 32: width of the search-cycle counter.
- TIMEOUT, 32'hFFFF_FFFF: cycle count at which the timeout flag is raised.
- BLINK_DIV, 25_000_000: half-period, in clk cycles, of the not-found blink (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle start request.
- crk_rdy  in  1  cracker idle and able to accept en.
- crk_en  out  1  single-cycle launch pulse to the cracker.
- crk_key  in  24  key from the cracker; meaningful only while crk_key_valid=1.
- crk_key_valid  in  1  key found (cracker status).
- busy  out  1  search in progress.
- done  out  1  result held on the displays.
- found  out  1  captured crk_key_valid.
- key_q  out  24  captured key.
- cycles  out  CNT_W  search duration in clk cycles, saturating.
- timeout  out  1  cycles reached TIMEOUT.
- hex0..hex5  out  7 each  segments {g,f,e,d,c,b,a}, active-low; hex5 shows key[23:20], hex0 shows key[3:0].

Behaviour:
- Reset (rst=1 sampled at posedge):
  - state=IDLE; crk_en, busy, done, found, timeout = 0; key_q=0; cycles=0.
  - All hex = 7'h7F (blank).
  - Reset takes priority over every other input.
  - The cracker is not reset by this block; it shares rst at top level.
- IDLE: start=1 -> LAUNCH; displays blank; busy=0, done=0.
- LAUNCH:
  - Wait for crk_rdy=1. In the first cycle crk_rdy=1, drive crk_en=1 for exactly that one cycle, clear cycles and timeout, set busy=1, then go to WAIT_LO.
  - start is ignored in LAUNCH.
- WAIT_LO: wait for crk_rdy=0, then go to WAIT_HI. cycles increments every cycle.
- WAIT_HI:
  - cycles increments every cycle.
  - When crk_rdy=1: capture key_q = crk_key_valid ? crk_key : 24'h0, capture found = crk_key_valid, then go to SHOW.
- Counter rules:
  - cycles saturates at all-ones and never wraps.
  - timeout sets when cycles == TIMEOUT and stays set until the next launch.
  - A timeout is a flag only; the search is never aborted.
- SHOW:
  - busy=0, done=1.
  - found=1: hexN shows the hex digit key_q[4N+3:4N] using the standard patterns (0=7'h40, 1=7'h79, E=7'h06, F=7'h0E).
  - found=0: all digits show a dash, 7'h3F.
  - start=1 -> LAUNCH (done clears and displays blank in the next cycle).
- Timing:
  - Model convention: the model raises crk_rdy on the Nth posedge after the posedge that samples crk_en=1.
  - With that convention, cycles = N.
  - crk_en is never asserted outside LAUNCH.
  - crk_en is never high for two consecutive cycles.
- Boundary cases:
  - start held high for many cycles launches only once, because start is ignored outside IDLE and SHOW.
  - crk_rdy already low in LAUNCH: stall; crk_en stays 0.
  - crk_rdy dropping and rising in the same state visit is not possible (one sample per cycle). A model whose rdy never drops leaves the block in WAIT_LO, with busy=1 and timeout eventually set.
  - rst mid-search returns the block to IDLE immediately.

Optional Feature:
- Macro: CRACK_REPORT_BLINK_EN.
- Defined: in SHOW with found=0, a BLINK_DIV counter toggles the dashes between 7'h3F and blank (7'h7F) every BLINK_DIV cycles. The phase starts at dashes-on when SHOW is entered. The counter resets with rst and on SHOW entry.
- Not defined: dashes are steady and no blink counter is synthesised.

Decomposition:
- Package crack_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT_LO, WAIT_HI, SHOW};
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - KEY_W=24.
- Sub-module hex7seg: combinational 4-bit to 7-bit active-low decoder, instantiated six times; blanking is muxed outside it.

Test Plan:
- Find: start pulse, model key 24'h1E4600, found after N=1000 -> one crk_en pulse; found=1; key_q=24'h1E4600; cycles=1000; hex5..hex0 = 79,06,19,02,40,40.
- Not found: model crk_key_valid=0, N=50 -> found=0; key_q=0; all hex=7'h3F (steady without the macro; toggling every BLINK_DIV=4 cycles with the macro and the parameter overridden).
- Cracker busy: crk_rdy held 0 for 20 cycles after start -> crk_en stays 0 until the first crk_rdy=1 cycle, then a single pulse.
- Timeout: TIMEOUT=100, N=150 -> timeout rises when cycles reaches 100; search completes; cycles=150; done=1.
- Ignored start and relaunch: start during WAIT_HI -> no crk_en; start in SHOW -> displays blank, new crk_en, timeout cleared.
- Mid-search reset: rst asserted in WAIT_HI -> next cycle all outputs at reset values; the state returns to IDLE.
